// File: rtl/scandoubler_ctrl_if.sv
// Video timing inputs, user requests and scandoubler mode outputs of scandoubler_ctrl.
// The master drives video timing and requests; the slave (the controller) returns mode status.
interface scandoubler_ctrl_if;
    logic        ce_pix;
    logic        hs_in;
    logic        vs_in;
    logic        force_sd;
    logic        hq2x_req;
    logic        sd_en;
    logic        hq2x_en;
    logic        locked;
    logic        is_15k;
    logic [11:0] line_pix;
    logic [10:0] frame_lines;
    logic        mode_chg;

    modport master (
        output ce_pix, hs_in, vs_in, force_sd, hq2x_req,
        input  sd_en, hq2x_en, locked, is_15k, line_pix, frame_lines, mode_chg
    );

    modport slave (
        input  ce_pix, hs_in, vs_in, force_sd, hq2x_req,
        output sd_en, hq2x_en, locked, is_15k, line_pix, frame_lines, mode_chg
    );
endinterface

// File: rtl/scandoubler_ctrl.sv
// Measures incoming video line/frame timing, locks onto stable timing and decides when
// the scandoubler (and HQ2x) is enabled; mode changes are applied only at frame start.
module scandoubler_ctrl #(
    parameter logic [15:0] HTHRESH       = 16'd4800,
    parameter logic [2:0]  STABLE_FRAMES = 3'd4,
    parameter logic [15:0] TIMEOUT       = 16'hFFFF
) (
    input logic               clk_sys,
    input logic               reset_n,
    scandoubler_ctrl_if.slave vid
);

    typedef enum logic [1:0] {NOSIG, SEARCH, VERIFY, LOCK} state_t;

    localparam logic [2:0] LOCK_CNT = STABLE_FRAMES - 3'd1;

    state_t      state_q, state_d;
    logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
    logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic [15:0] cyc_q, cyc_d;
    logic [11:0] pix_q, pix_d;
    logic [10:0] lines_q, lines_d;
    logic [15:0] snap_cyc_q, snap_cyc_d;
    logic [11:0] snap_pix_q, snap_pix_d;
    logic        frame_ok_q, frame_ok_d;
    logic [15:0] ref_cyc_q, ref_cyc_d;
    logic [11:0] ref_pix_q, ref_pix_d;
    logic [10:0] ref_lines_q, ref_lines_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [11:0] line_pix_q, line_pix_d;
    logic [10:0] frame_lines_q, frame_lines_d;
    logic        sd_en_q, sd_en_d;
    logic        hq2x_en_q, hq2x_en_d;
    logic        mode_chg_q, mode_chg_d;

    logic        hs_fall, vs_fall;
    logic        line_ok, frame_match;
    logic [16:0] cyc_x, ref_x;
    logic        sd_t, hq_t, upd;

    assign hs_fall = hs_prev_q & ~hs_q;
    assign vs_fall = vs_prev_q & ~vs_q;

    assign cyc_x       = {1'b0, cyc_q};
    assign ref_x       = {1'b0, ref_cyc_q};
    assign line_ok     = (pix_q == ref_pix_q) && (cyc_x + 17'd2 >= ref_x) && (cyc_x <= ref_x + 17'd2);
    // The line closed by an hs edge coincident with vs still belongs to the ending frame.
    assign frame_match = frame_ok_q && (!hs_fall || line_ok) && (lines_q == ref_lines_q);

    always_comb begin
        hs_d       = vid.hs_in;
        vs_d       = vid.vs_in;
        hs_prev_d  = hs_q;
        vs_prev_d  = vs_q;
        cyc_d      = cyc_q;
        pix_d      = pix_q;
        lines_d    = lines_q;
        snap_cyc_d = snap_cyc_q;
        snap_pix_d = snap_pix_q;
        frame_ok_d = frame_ok_q;

        if (hs_fall) begin
            cyc_d      = 16'd1;
            pix_d      = {11'd0, vid.ce_pix};
            snap_cyc_d = cyc_q;
            snap_pix_d = pix_q;
        end else begin
            if (cyc_q != '1) cyc_d = cyc_q + 16'd1;
            if (vid.ce_pix && (pix_q != '1)) pix_d = pix_q + 12'd1;
        end

        if (vs_fall) begin
            lines_d    = {10'd0, hs_fall};
            frame_ok_d = 1'b1;
        end else if (hs_fall) begin
            if (lines_q != '1) lines_d = lines_q + 11'd1;
            frame_ok_d = frame_ok_q & line_ok;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        ref_cyc_d   = ref_cyc_q;
        ref_pix_d   = ref_pix_q;
        ref_lines_d = ref_lines_q;

        if (!hs_fall && (cyc_q >= TIMEOUT)) begin
            state_d = NOSIG;
        end else begin
            unique case (state_q)
                NOSIG: begin
                    if (hs_fall) state_d = SEARCH;
                end
                SEARCH, VERIFY: begin
                    if (vs_fall) begin
                        if ((state_q == VERIFY) && frame_match) begin
                            if (fcnt_q != '1) fcnt_d = fcnt_q + 3'd1;
                            if (fcnt_d >= LOCK_CNT) state_d = LOCK;
                        end else begin
                            ref_cyc_d   = hs_fall ? cyc_q : snap_cyc_q;
                            ref_pix_d   = hs_fall ? pix_q : snap_pix_q;
                            ref_lines_d = lines_q;
                            fcnt_d      = '0;
                            state_d     = VERIFY;
                        end
                    end
                end
                LOCK: begin
                    if ((hs_fall && !line_ok) || (vs_fall && !frame_match)) state_d = SEARCH;
                end
                default: state_d = NOSIG;
            endcase
        end
    end

    always_comb begin
        // Target uses the next state so the enable follows lock on the very vs edge that locks.
        sd_t          = vid.force_sd | ((state_d == LOCK) && (ref_cyc_q >= HTHRESH));
        hq_t          = sd_t & vid.hq2x_req;
        upd           = vs_fall || (state_q == NOSIG);
        sd_en_d       = upd ? sd_t : sd_en_q;
        hq2x_en_d     = upd ? hq_t : hq2x_en_q;
        mode_chg_d    = (sd_en_d != sd_en_q) || (hq2x_en_d != hq2x_en_q);
        line_pix_d    = (state_d == LOCK) ? ref_pix_q : line_pix_q;
        frame_lines_d = (state_d == LOCK) ? ref_lines_q : frame_lines_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= NOSIG;
            hs_q          <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_q          <= 1'b0;
            vs_prev_q     <= 1'b0;
            cyc_q         <= '0;
            pix_q         <= '0;
            lines_q       <= '0;
            snap_cyc_q    <= '0;
            snap_pix_q    <= '0;
            frame_ok_q    <= 1'b0;
            ref_cyc_q     <= '0;
            ref_pix_q     <= '0;
            ref_lines_q   <= '0;
            fcnt_q        <= '0;
            line_pix_q    <= '0;
            frame_lines_q <= '0;
            sd_en_q       <= 1'b0;
            hq2x_en_q     <= 1'b0;
            mode_chg_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            hs_prev_q     <= hs_prev_d;
            vs_q          <= vs_d;
            vs_prev_q     <= vs_prev_d;
            cyc_q         <= cyc_d;
            pix_q         <= pix_d;
            lines_q       <= lines_d;
            snap_cyc_q    <= snap_cyc_d;
            snap_pix_q    <= snap_pix_d;
            frame_ok_q    <= frame_ok_d;
            ref_cyc_q     <= ref_cyc_d;
            ref_pix_q     <= ref_pix_d;
            ref_lines_q   <= ref_lines_d;
            fcnt_q        <= fcnt_d;
            line_pix_q    <= line_pix_d;
            frame_lines_q <= frame_lines_d;
            sd_en_q       <= sd_en_d;
            hq2x_en_q     <= hq2x_en_d;
            mode_chg_q    <= mode_chg_d;
        end
    end

    assign vid.locked      = (state_q == LOCK);
    assign vid.is_15k      = (state_q == LOCK) && (ref_cyc_q >= HTHRESH);
    assign vid.line_pix    = line_pix_q;
    assign vid.frame_lines = frame_lines_q;
    assign vid.sd_en       = sd_en_q;
    assign vid.hq2x_en     = hq2x_en_q;
    assign vid.mode_chg    = mode_chg_q;

endmodule
